// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int unsigned STALL_CNT_W = 16;

  // Index width that stays >= 1 even for a single-entry range.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set req bit after last_grant, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] pick,
  output logic             any_req
);

  int unsigned cand;
  logic        found;

  // Candidates are visited last_grant+1 .. last_grant+N_REQ, so last_grant itself comes last.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = (32'(last_grant) + i) % N_REQ;
      if (!found && req[IDX_W'(cand)]) begin
        pick  = IDX_W'(cand);
        found = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers, with bursts.
// Optional stall counter output enabled by defining FIFO_WR_ARBITER_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned WIDTH     = 8,
  parameter  int unsigned N_REQ     = 4,
  parameter  int unsigned MAX_BURST = 4,
  localparam int unsigned IDX_W     = idx_w(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       ack,
  input  logic                   fifo_full,
  input  logic                   fifo_afull,
  output logic                   fifo_wr_en,
  output logic [WIDTH-1:0]       fifo_data,
  output logic [IDX_W-1:0]       grant_id,
  output logic                   busy
`ifdef FIFO_WR_ARBITER_STATS_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  localparam int unsigned          BURST_W    = idx_w(MAX_BURST);
  localparam logic [BURST_W-1:0]   BURST_LAST = BURST_W'(MAX_BURST - 1);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   grant_id_q, grant_id_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic               fifo_wr_en_q, fifo_wr_en_d;
  logic [WIDTH-1:0]   fifo_data_q, fifo_data_d;

  logic [WIDTH-1:0]   req_arr [N_REQ];
  logic [IDX_W-1:0]   pick;
  logic               any_req;
  logic               grant_req_c;
  logic               accept_c;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign req_arr[gi] = req_data[gi*WIDTH +: WIDTH];
  end

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req        (req),
    .last_grant (last_grant_q),
    .pick       (pick),
    .any_req    (any_req)
  );

  // The afull term covers the write already registered but not yet seen by the FIFO.
  assign grant_req_c = req[grant_id_q];
  assign accept_c    = (state_q == GRANT) && grant_req_c && !fifo_full &&
                       !(fifo_wr_en_q && fifo_afull);

  always_comb begin
    ack = '0;
    if (accept_c) ack[grant_id_q] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    fifo_wr_en_d = 1'b0;
    fifo_data_d  = fifo_data_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_id_d   = pick;
          last_grant_d = pick;
          burst_cnt_d  = '0;
          state_d      = GRANT;
        end
      end
      GRANT: begin
        if (accept_c) begin
          fifo_wr_en_d = 1'b1;
          fifo_data_d  = req_arr[grant_id_q];
          if (burst_cnt_q == BURST_LAST) state_d = IDLE;
          else burst_cnt_d = burst_cnt_q + BURST_W'(1);
        end
        if (!grant_req_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_id_q   <= '0;
      last_grant_q <= IDX_W'(N_REQ - 1);
      burst_cnt_q  <= '0;
      fifo_wr_en_q <= 1'b0;
      fifo_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      fifo_wr_en_q <= fifo_wr_en_d;
      fifo_data_q  <= fifo_data_d;
    end
  end

  assign fifo_wr_en = fifo_wr_en_q;
  assign fifo_data  = fifo_data_q;
  assign grant_id   = grant_id_q;
  assign busy       = (state_q == GRANT);

`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of granted-but-blocked cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == GRANT) && grant_req_c && !accept_c && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus a randomized run against a reference model.
module tb_fifo_wr_arbiter;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int MAXB = 4;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   ack;
  logic           fifo_full;
  logic           fifo_afull;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_data;
  logic [1:0]     grant_id;
  logic           busy;
`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [15:0]    stall_cnt;
`endif

  int checks;
  int failures;

  // Producer queues and per-cycle logs
  logic [W-1:0]   pq [N][$];
  bit             gap [N];
  bit             withdraw [N];
  bit             gap_mode;
  bit             full_v, afull_v;
  logic [N-1:0]   ack_log[$], req_log[$];
  logic [N*W-1:0] rd_log[$];
  bit             full_log[$], afull_log[$], wr_log[$], busy_log[$];
  logic [W-1:0]   data_log[$];
  logic [1:0]     gid_log[$];

  fifo_wr_arbiter #(.WIDTH(W), .N_REQ(N), .MAX_BURST(MAXB)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .fifo_full  (fifo_full),
    .fifo_afull (fifo_afull),
    .fifo_wr_en (fifo_wr_en),
    .fifo_data  (fifo_data),
    .grant_id   (grant_id),
    .busy       (busy)
`ifdef FIFO_WR_ARBITER_STATS_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_logs();
    ack_log.delete(); req_log.delete(); rd_log.delete(); full_log.delete();
    afull_log.delete(); wr_log.delete(); busy_log.delete(); data_log.delete(); gid_log.delete();
    for (int i = 0; i < N; i++) begin
      pq[i].delete(); gap[i] = 1'b0; withdraw[i] = 1'b0;
    end
    gap_mode = 1'b0; full_v = 1'b0; afull_v = 1'b0;
  endtask

  // Called at posedge+1; leaves the bench at the next posedge+1.
  task automatic apply_reset();
    req = '0; req_data = '0; fifo_full = 1'b0; fifo_afull = 1'b0;
    #2 reset = 1'b1;
    #3 reset = 1'b0;
    clear_logs();
    @(posedge clk); #1;
  endtask

  // One clock of producer behaviour; records inputs, ack and registered outputs.
  task automatic tick();
    logic [N-1:0]   r;
    logic [N*W-1:0] d;
    logic [N-1:0]   a;
    r = '0; d = '0;
    for (int i = 0; i < N; i++)
      if (pq[i].size() > 0 && !gap[i] && !withdraw[i]) begin
        r[i] = 1'b1;
        d[i*W +: W] = pq[i][0];
      end
    req = r; req_data = d; fifo_full = full_v; fifo_afull = afull_v;
    #3 a = ack;
    ack_log.push_back(a); req_log.push_back(r); rd_log.push_back(d);
    full_log.push_back(full_v); afull_log.push_back(afull_v);
    @(posedge clk); #1;
    wr_log.push_back(fifo_wr_en); data_log.push_back(fifo_data);
    busy_log.push_back(busy); gid_log.push_back(grant_id);
    for (int i = 0; i < N; i++) begin
      gap[i] = 1'b0;
      if (a[i]) begin
        void'(pq[i].pop_front());
        gap[i] = gap_mode;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '1; req_data = '1; fifo_full = 1'b0; fifo_afull = 1'b0;
    @(posedge clk); #1;
    checks++; if (fifo_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", fifo_wr_en); end
    checks++; if (fifo_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", fifo_data); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL reset_ack got=%b exp=0000", ack); end
`ifdef FIFO_WR_ARBITER_STATS_EN
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
`endif
    req = '0; req_data = '0;
    #2 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    apply_reset();
    pq[1].push_back(8'hA5);
    gap_mode = 1'b1;
    for (int t = 0; t < 3; t++) tick();
    checks++; if (ack_log[0] !== 4'b0000) begin failures++; $display("FAIL single_bubble_ack got=%b exp=0000", ack_log[0]); end
    checks++; if (busy_log[0] !== 1'b1 || gid_log[0] !== 2'd1) begin failures++; $display("FAIL single_grant got=%b/%0d exp=1/1", busy_log[0], gid_log[0]); end
    checks++; if (ack_log[1] !== 4'b0010) begin failures++; $display("FAIL single_ack got=%b exp=0010", ack_log[1]); end
    checks++; if (wr_log[0] !== 1'b0) begin failures++; $display("FAIL single_early_wr got=%b exp=0", wr_log[0]); end
    checks++; if (wr_log[1] !== 1'b1 || data_log[1] !== 8'hA5) begin failures++; $display("FAIL single_write got=%b/%h exp=1/a5", wr_log[1], data_log[1]); end
    checks++; if (busy_log[2] !== 1'b0 || wr_log[2] !== 1'b0) begin failures++; $display("FAIL single_release got=%b/%b exp=0/0", busy_log[2], wr_log[2]); end
  endtask

  task automatic test_burst_limit();
    logic [N-1:0] exp_ack [9] = '{0, 1, 1, 1, 1, 0, 1, 1, 0};
    logic [W-1:0] wq[$];
    apply_reset();
    for (int i = 1; i <= 6; i++) pq[0].push_back(W'(i));
    for (int t = 0; t < 9; t++) tick();
    for (int k = 0; k < 9; k++) begin
      checks++; if (ack_log[k] !== exp_ack[k]) begin failures++; $display("FAIL burst_ack[%0d] got=%b exp=%b", k, ack_log[k], exp_ack[k]); end
    end
    checks++; if (busy_log[4] !== 1'b0) begin failures++; $display("FAIL burst_bubble got=%b exp=0", busy_log[4]); end
    checks++; if (busy_log[5] !== 1'b1 || gid_log[5] !== 2'd0) begin failures++; $display("FAIL burst_regrant got=%b/%0d exp=1/0", busy_log[5], gid_log[5]); end
    for (int k = 0; k < wr_log.size(); k++) if (wr_log[k]) wq.push_back(data_log[k]);
    checks++; if (wq.size() != 6) begin failures++; $display("FAIL burst_write_count got=%0d exp=6", wq.size()); end
    for (int k = 0; k < wq.size() && k < 6; k++) begin
      checks++; if (wq[k] !== W'(k + 1)) begin failures++; $display("FAIL burst_write[%0d] got=%h exp=%h", k, wq[k], W'(k + 1)); end
    end
  endtask

  task automatic test_round_robin();
    int           exp_g [5] = '{0, 1, 2, 3, 0};
    int           gl[$];
    logic [W-1:0] wq[$];
    apply_reset();
    gap_mode = 1'b1;
    pq[0].push_back(8'd1); pq[1].push_back(8'd2); pq[2].push_back(8'd3);
    pq[3].push_back(8'd4); pq[0].push_back(8'd5);
    for (int t = 0; t < 16; t++) tick();
    for (int k = 0; k < busy_log.size(); k++)
      if (busy_log[k] && (k == 0 || !busy_log[k-1])) gl.push_back(int'(gid_log[k]));
    for (int k = 0; k < wr_log.size(); k++) if (wr_log[k]) wq.push_back(data_log[k]);
    checks++; if (gl.size() != 5) begin failures++; $display("FAIL rr_grant_count got=%0d exp=5", gl.size()); end
    for (int k = 0; k < gl.size() && k < 5; k++) begin
      checks++; if (gl[k] != exp_g[k]) begin failures++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", k, gl[k], exp_g[k]); end
    end
    checks++; if (wq.size() != 5) begin failures++; $display("FAIL rr_write_count got=%0d exp=5", wq.size()); end
  endtask

  task automatic test_backpressure();
    bit           fs [10] = '{0, 0, 1, 1, 1, 1, 1, 0, 0, 0};
    bit           as [10] = '{0, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    logic [N-1:0] exp_ack [10] = '{0, 1, 0, 0, 0, 0, 0, 1, 1, 1};
    logic [W-1:0] wq[$];
    apply_reset();
    for (int i = 0; i < 4; i++) pq[0].push_back(W'(8'h10 + i));
    for (int t = 0; t < 10; t++) begin
      full_v = fs[t]; afull_v = as[t];
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      checks++; if (ack_log[k] !== exp_ack[k]) begin failures++; $display("FAIL bp_ack[%0d] got=%b exp=%b", k, ack_log[k], exp_ack[k]); end
    end
    for (int k = 2; k <= 6; k++) begin
      checks++; if (wr_log[k] !== 1'b0 || busy_log[k] !== 1'b1 || gid_log[k] !== 2'd0) begin
        failures++; $display("FAIL bp_hold[%0d] got=wr%b/busy%b/g%0d exp=wr0/busy1/g0", k, wr_log[k], busy_log[k], gid_log[k]);
      end
    end
    for (int k = 0; k < wr_log.size(); k++) if (wr_log[k]) wq.push_back(data_log[k]);
    checks++; if (wq.size() != 4) begin failures++; $display("FAIL bp_write_count got=%0d exp=4", wq.size()); end
    for (int k = 0; k < wq.size() && k < 4; k++) begin
      checks++; if (wq[k] !== W'(8'h10 + k)) begin failures++; $display("FAIL bp_write[%0d] got=%h exp=%h", k, wq[k], W'(8'h10 + k)); end
    end
    checks++; if (busy_log[9] !== 1'b0) begin failures++; $display("FAIL bp_end_busy got=%b exp=0", busy_log[9]); end
`ifdef FIFO_WR_ARBITER_STATS_EN
    checks++; if (stall_cnt !== 16'd5) begin failures++; $display("FAIL bp_stall_cnt got=%0d exp=5", stall_cnt); end
`endif
  endtask

  task automatic test_afull_alternate();
    logic [N-1:0] exp_ack [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
    apply_reset();
    for (int i = 0; i < 4; i++) pq[0].push_back(W'(8'h20 + i));
    afull_v = 1'b1;
    for (int t = 0; t < 8; t++) tick();
    for (int k = 0; k < 8; k++) begin
      checks++; if (ack_log[k] !== exp_ack[k]) begin failures++; $display("FAIL afull_ack[%0d] got=%b exp=%b", k, ack_log[k], exp_ack[k]); end
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    for (int i = 0; i < 6; i++) pq[0].push_back(W'(8'h40 + i));
    tick(); tick(); tick();
    checks++; if (fifo_wr_en !== 1'b1 || ack !== 4'b0001) begin failures++; $display("FAIL mid_pre got=wr%b/ack%b exp=wr1/ack0001", fifo_wr_en, ack); end
    #2 reset = 1'b1;
    #1;
    checks++; if (fifo_wr_en !== 1'b0) begin failures++; $display("FAIL mid_wr_en got=%b exp=0", fifo_wr_en); end
    checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL mid_ack got=%b exp=0000", ack); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
    req = '0; req_data = '0;
    clear_logs();
    #2 reset = 1'b0;
    pq[0].push_back(8'h51); pq[2].push_back(8'h53);
    @(posedge clk); #1;
    tick();
    checks++; if (busy_log[0] !== 1'b1 || gid_log[0] !== 2'd0) begin failures++; $display("FAIL mid_first_grant got=%b/%0d exp=1/0", busy_log[0], gid_log[0]); end
  endtask

  task automatic test_withdraw();
    apply_reset();
    pq[2].push_back(8'h77);
    full_v = 1'b1;
    tick();
    withdraw[2] = 1'b1;
    tick();
    withdraw[2] = 1'b0; full_v = 1'b0;
    pq[3].push_back(8'h33);
    tick();
    checks++; if (gid_log[0] !== 2'd2) begin failures++; $display("FAIL wd_grant got=%0d exp=2", gid_log[0]); end
    checks++; if (ack_log[0] !== 4'b0000 || ack_log[1] !== 4'b0000) begin failures++; $display("FAIL wd_ack got=%b/%b exp=0000/0000", ack_log[0], ack_log[1]); end
    checks++; if (busy_log[1] !== 1'b0 || wr_log[1] !== 1'b0) begin failures++; $display("FAIL wd_release got=%b/%b exp=0/0", busy_log[1], wr_log[1]); end
    checks++; if (gid_log[2] !== 2'd3) begin failures++; $display("FAIL wd_next_pick got=%0d exp=3", gid_log[2]); end
  endtask

  task automatic test_random();
    bit           m_busy, m_wr, acc;
    int           m_g, m_last, m_cnt, nerr;
    logic [W-1:0] m_data;
    logic [N-1:0] r, exp_ack;
    apply_reset();
    for (int t = 0; t < 600; t++) begin
      if (t % 150 == 0) gap_mode = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < N; i++) begin
        if (pq[i].size() < 3 && $urandom_range(0, 3) == 0) pq[i].push_back(W'($urandom));
        withdraw[i] = ($urandom_range(0, 15) == 0);
      end
      full_v  = ($urandom_range(0, 4) == 0);
      afull_v = ($urandom_range(0, 2) == 0);
      tick();
    end
    // Reference: grant, then accept beats until the producer drops or MAXB beats go through.
    m_busy = 1'b0; m_wr = 1'b0; m_g = 0; m_last = N - 1; m_cnt = 0; m_data = '0; nerr = 0;
    for (int k = 0; k < ack_log.size(); k++) begin
      r = req_log[k];
      acc = m_busy && r[2'(m_g)] && !full_log[k] && !(m_wr && afull_log[k]);
      exp_ack = acc ? (4'b0001 << m_g) : 4'b0000;
      if (!m_busy) begin
        m_wr = 1'b0;
        for (int s = 1; s <= N; s++)
          if (!m_busy && r[2'((m_last + s) % N)]) begin
            m_g = (m_last + s) % N; m_last = m_g; m_cnt = 0; m_busy = 1'b1;
          end
      end else begin
        m_wr = acc;
        if (acc) begin
          m_data = rd_log[k][m_g*W +: W];
          m_cnt++;
        end
        if (!r[2'(m_g)] || (acc && m_cnt == MAXB)) m_busy = 1'b0;
      end
      checks++;
      if (ack_log[k] !== exp_ack || wr_log[k] !== m_wr || busy_log[k] !== m_busy ||
          gid_log[k] !== 2'(m_g) || (m_wr && data_log[k] !== m_data)) begin
        failures++; nerr++;
        if (nerr <= 10)
          $display("FAIL rand[%0d] got=ack%b/wr%b/d%h/busy%b/g%0d exp=ack%b/wr%b/d%h/busy%b/g%0d", k,
                   ack_log[k], wr_log[k], data_log[k], busy_log[k], gid_log[k],
                   exp_ack, m_wr, m_data, m_busy, m_g);
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    clear_logs();
    reset = 1'b1; req = '0; req_data = '0; fifo_full = 1'b0; fifo_afull = 1'b0;
    test_reset();
    test_single();
    test_burst_limit();
    test_round_robin();
    test_backpressure();
    test_afull_alternate();
    test_reset_mid_burst();
    test_withdraw();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
